video_stream_monitor: RTL and testbench



---
 rtl/vid_stream_pkg.sv | 26 ++
 rtl/vid_edge_det.sv | 29 ++
 rtl/video_stream_monitor.sv | 192 +++++++++++++++++++
 tb/tb_video_stream_monitor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_stream_pkg.sv
// Shared types and helpers for the video stream monitors.
// The meas_t bundle is the per-frame result record other monitors will reuse.
package vid_stream_pkg;

    localparam int XRES_W = 16;
    localparam int CNT_W  = 32;

    typedef struct packed {
        logic [XRES_W-1:0] xres;
        logic [XRES_W-1:0] yres;
        logic              err_line;
        logic              err_frame;
        logic              err_sync;
    } meas_t;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } mon_state_t;

    // Saturating increment for geometry counters.
    function automatic logic [XRES_W-1:0] sat_inc(input logic [XRES_W-1:0] v);
        return (&v) ? v : v + XRES_W'(1);
    endfunction

endpackage

// File: rtl/vid_edge_det.sv
// Registered edge detector: pulse follows the current input against its
// one-cycle-old copy, rising or falling edge selected by RISING.
module vid_edge_det #(
    parameter bit RISING = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic din_d;
    logic din_q;

    always_comb begin
        din_d = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din_d;
        end
    end

    assign pulse = RISING ? (din & ~din_q) : (~din & din_q);

endmodule

// File: rtl/video_stream_monitor.sv
// Sink-side monitor for the vsync/hsync/valid pixel stream: measures the
// received geometry, counts frames and checksums each frame's pixels.
module video_stream_monitor
    import vid_stream_pkg::*;
#(
    parameter int       DATA_WIDTH = 8,
    parameter int       H_DISP     = 800,
    parameter int       V_DISP     = 600,
    parameter bit       VSYNC_POL  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vin_vsync,
    input  logic                  vin_hsync,
    input  logic                  vin_valid,
    input  logic [DATA_WIDTH-1:0] vin_data,
    output logic [XRES_W-1:0]     meas_xres,
    output logic [XRES_W-1:0]     meas_yres,
    output logic                  meas_valid,
    output logic                  frame_done,
    output logic [CNT_W-1:0]      frame_cnt,
    output logic [CNT_W-1:0]      frame_sum,
    output logic                  err_line,
    output logic                  err_frame,
    output logic                  err_sync
);

    logic vs_act;
    logic pix_valid;
    logic sync_pix;
    logic frame_edge;
    logic line_end;
    logic unused_hsync;

    assign unused_hsync = vin_hsync;
    assign vs_act       = (vin_vsync == VSYNC_POL);
    // Valid is masked by vsync so that a pixel during sync never opens a
    // line, and a line still open when sync arrives ends on that same cycle.
    assign pix_valid    = vin_valid & ~vs_act;
    assign sync_pix     = vin_valid & vs_act;

    vid_edge_det #(.RISING(1'b1)) u_vsync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (vs_act),
        .pulse (frame_edge)
    );

    vid_edge_det #(.RISING(1'b0)) u_valid_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pix_valid),
        .pulse (line_end)
    );

    mon_state_t        state_q, state_d;
    logic [XRES_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [XRES_W-1:0] line_cnt_q, line_cnt_d;
    logic [XRES_W-1:0] first_len_q, first_len_d;
    logic [CNT_W-1:0]  sum_q, sum_d;
    logic              e_line_q, e_line_d;
    logic              e_sync_q, e_sync_d;
    meas_t             meas_q, meas_d;
    logic              meas_valid_q, meas_valid_d;
    logic              frame_done_q, frame_done_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]  frame_sum_q, frame_sum_d;

    // Accumulator values with the current cycle's pixel and line end applied.
    logic [XRES_W-1:0] pix_cl;
    logic [XRES_W-1:0] line_cl;
    logic [XRES_W-1:0] first_cl;
    logic [CNT_W-1:0]  sum_cl;
    logic              e_line_cl;

    always_comb begin
        pix_cl    = pix_valid ? sat_inc(pix_cnt_q) : pix_cnt_q;
        sum_cl    = sum_q + (pix_valid ? CNT_W'(vin_data) : CNT_W'(0));
        line_cl   = line_cnt_q;
        first_cl  = first_len_q;
        e_line_cl = e_line_q;
        if (line_end) begin
            line_cl   = sat_inc(line_cnt_q);
            pix_cl    = '0;
            if (line_cnt_q == '0) begin
                first_cl = pix_cnt_q;
            end
            if (pix_cnt_q != XRES_W'(H_DISP)) begin
                e_line_cl = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        first_len_d  = first_len_q;
        sum_d        = sum_q;
        e_line_d     = e_line_q;
        e_sync_d     = e_sync_q;
        meas_d       = meas_q;
        meas_valid_d = meas_valid_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        frame_sum_d  = frame_sum_q;

        case (state_q)
            ST_UNLOCKED: begin
                if (frame_edge) begin
                    state_d     = ST_LOCKED;
                    pix_cnt_d   = '0;
                    line_cnt_d  = '0;
                    first_len_d = '0;
                    sum_d       = '0;
                    e_line_d    = 1'b0;
                    e_sync_d    = sync_pix;
                end
            end
            ST_LOCKED: begin
                if (frame_edge) begin
                    if (line_cl != '0) begin
                        meas_d.xres      = first_cl;
                        meas_d.yres      = line_cl;
                        meas_d.err_line  = e_line_cl;
                        meas_d.err_frame = (line_cl != XRES_W'(V_DISP));
                        meas_d.err_sync  = e_sync_q;
                        frame_sum_d      = sum_cl;
                        frame_cnt_d      = frame_cnt_q + CNT_W'(1);
                        meas_valid_d     = 1'b1;
                        frame_done_d     = 1'b1;
                    end
                    pix_cnt_d   = '0;
                    line_cnt_d  = '0;
                    first_len_d = '0;
                    sum_d       = '0;
                    e_line_d    = 1'b0;
                    e_sync_d    = sync_pix;
                end else begin
                    pix_cnt_d   = pix_cl;
                    line_cnt_d  = line_cl;
                    first_len_d = first_cl;
                    sum_d       = sum_cl;
                    e_line_d    = e_line_cl;
                    e_sync_d    = e_sync_q | sync_pix;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_UNLOCKED;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            first_len_q  <= '0;
            sum_q        <= '0;
            e_line_q     <= 1'b0;
            e_sync_q     <= 1'b0;
            meas_q       <= '0;
            meas_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            frame_sum_q  <= '0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            first_len_q  <= first_len_d;
            sum_q        <= sum_d;
            e_line_q     <= e_line_d;
            e_sync_q     <= e_sync_d;
            meas_q       <= meas_d;
            meas_valid_q <= meas_valid_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_sum_q  <= frame_sum_d;
        end
    end

    assign meas_xres  = meas_q.xres;
    assign meas_yres  = meas_q.yres;
    assign err_line   = meas_q.err_line;
    assign err_frame  = meas_q.err_frame;
    assign err_sync   = meas_q.err_sync;
    assign meas_valid = meas_valid_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign frame_sum  = frame_sum_q;

endmodule

// File: tb/tb_video_stream_monitor.sv
// Self-checking bench for video_stream_monitor with an 8x4 expected geometry;
// frames are described as lists of line lengths and checked against a model.
module tb_video_stream_monitor;

    localparam int DW = 8;
    localparam int HD = 8;
    localparam int VD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vin_vsync = 1'b0;
    logic          vin_hsync = 1'b0;
    logic          vin_valid = 1'b0;
    logic [DW-1:0] vin_data = '0;
    logic [15:0]   meas_xres;
    logic [15:0]   meas_yres;
    logic          meas_valid;
    logic          frame_done;
    logic [31:0]   frame_cnt;
    logic [31:0]   frame_sum;
    logic          err_line;
    logic          err_frame;
    logic          err_sync;

    video_stream_monitor #(
        .DATA_WIDTH (DW),
        .H_DISP     (HD),
        .V_DISP     (VD),
        .VSYNC_POL  (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vin_vsync  (vin_vsync),
        .vin_hsync  (vin_hsync),
        .vin_valid  (vin_valid),
        .vin_data   (vin_data),
        .meas_xres  (meas_xres),
        .meas_yres  (meas_yres),
        .meas_valid (meas_valid),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .frame_sum  (frame_sum),
        .err_line   (err_line),
        .err_frame  (err_frame),
        .err_sync   (err_sync)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of the frame being received and of the outputs last reported.
    bit          m_locked = 1'b0;
    int          m_lines[$];
    logic [31:0] m_sum = '0;
    bit          m_esync = 1'b0;
    logic [15:0] x_xres = '0;
    logic [15:0] x_yres = '0;
    logic        x_valid = 1'b0;
    logic [31:0] x_cnt = '0;
    logic [31:0] x_sum = '0;
    logic        x_eline = 1'b0;
    logic        x_eframe = 1'b0;
    logic        x_esync = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear_outputs();
        x_xres = '0; x_yres = '0; x_valid = 1'b0; x_cnt = '0; x_sum = '0;
        x_eline = 1'b0; x_eframe = 1'b0; x_esync = 1'b0;
        m_locked = 1'b0; m_lines.delete(); m_sum = '0; m_esync = 1'b0;
    endtask

    // One line of len pixels; base < 0 gives random data, else data = x + base.
    task automatic send_line(input int len, input int base, input bit leave_open);
        for (int x = 0; x < len; x++) begin
            vin_valid = 1'b1;
            vin_data  = (base < 0) ? DW'($urandom) : DW'(x + base);
            m_sum     = m_sum + 32'(vin_data);
            step();
        end
        m_lines.push_back(len);
        if (!leave_open) begin
            vin_valid = 1'b0;
            repeat ($urandom_range(1, 3)) step();
        end
    endtask

    // Drives a vsync pulse and checks what the monitor reports for it.
    // glitch=1 puts a stray valid pixel in the second sync cycle.
    task automatic frame_edge_scenario(input string tag, input bit glitch);
        bit exp_done;
        bit open_valid;
        bit any_bad;
        exp_done   = m_locked && (m_lines.size() > 0);
        open_valid = vin_valid;
        if (exp_done) begin
            any_bad = 1'b0;
            foreach (m_lines[i]) if (m_lines[i] != HD) any_bad = 1'b1;
            x_xres   = 16'(m_lines[0]);
            x_yres   = 16'(m_lines.size());
            x_sum    = m_sum;
            x_cnt    = x_cnt + 1;
            x_valid  = 1'b1;
            x_eline  = any_bad;
            x_eframe = (m_lines.size() != VD);
            x_esync  = m_esync;
        end
        vin_vsync = 1'b1;
        if (vin_valid) vin_data = DW'($urandom);
        step();
        checks++;
        if (frame_done !== exp_done) begin
            errors++; $display("FAIL %s frame_done: got %0d expected %0d", tag, frame_done, exp_done);
        end
        checks++;
        if ({meas_xres, meas_yres, meas_valid, err_line, err_frame, err_sync}
            !== {x_xres, x_yres, x_valid, x_eline, x_eframe, x_esync}) begin
            errors++;
            $display("FAIL %s meas: got x=%0d y=%0d v=%0d el=%0d ef=%0d es=%0d expected x=%0d y=%0d v=%0d el=%0d ef=%0d es=%0d",
                     tag, meas_xres, meas_yres, meas_valid, err_line, err_frame, err_sync,
                     x_xres, x_yres, x_valid, x_eline, x_eframe, x_esync);
        end
        checks++;
        if (frame_cnt !== x_cnt) begin
            errors++; $display("FAIL %s frame_cnt: got %0d expected %0d", tag, frame_cnt, x_cnt);
        end
        checks++;
        if (frame_sum !== x_sum) begin
            errors++; $display("FAIL %s frame_sum: got %0d expected %0d", tag, frame_sum, x_sum);
        end
        m_locked = 1'b1;
        m_lines.delete();
        m_sum    = '0;
        m_esync  = open_valid;
        vin_valid = glitch;
        vin_data  = DW'($urandom);
        if (glitch) m_esync = 1'b1;
        step();
        checks++;
        if (frame_done !== 1'b0) begin
            errors++; $display("FAIL %s frame_done_width: got %0d expected 0", tag, frame_done);
        end
        vin_valid = 1'b0;
        vin_vsync = 1'b0;
        step();
        $display("edge %-10s done=%0d cnt=%0d x=%0d y=%0d sum=%0d el=%0d ef=%0d es=%0d", tag,
                 exp_done, frame_cnt, meas_xres, meas_yres, frame_sum, err_line, err_frame, err_sync);
    endtask

    task automatic send_frame(input int nlines, input int short_idx, input int base);
        for (int y = 0; y < nlines; y++) begin
            send_line((y == short_idx) ? HD - 1 : HD, (base < 0) ? -1 : base + y, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({meas_xres, meas_yres, meas_valid, frame_done, frame_cnt, frame_sum, err_line, err_frame, err_sync} !== '0) begin
            errors++; $display("FAIL reset_outputs: got nonzero outputs x=%0d y=%0d cnt=%0d sum=%0d expected all 0",
                               meas_xres, meas_yres, frame_cnt, frame_sum);
        end
        rst_n = 1'b1;
        step();
        $display("reset released");
    endtask

    task automatic test_prelock();
        send_line(HD, -1, 1'b0);
        send_line(HD, -1, 1'b0);
        frame_edge_scenario("lock", 1'b0);
    endtask

    task automatic test_clean();
        send_frame(VD, -1, 0);
        frame_edge_scenario("clean", 1'b0);
    endtask

    task automatic test_short_line();
        send_frame(VD, 1, -1);
        frame_edge_scenario("short", 1'b0);
        send_frame(VD, -1, -1);
        frame_edge_scenario("recover", 1'b0);
    endtask

    task automatic test_tall_and_empty();
        send_frame(VD + 1, -1, -1);
        frame_edge_scenario("tall", 1'b0);
        frame_edge_scenario("empty", 1'b0);
    endtask

    task automatic test_sync_glitch();
        frame_edge_scenario("glitch", 1'b1);
        send_frame(VD, -1, -1);
        frame_edge_scenario("after_gl", 1'b0);
        frame_edge_scenario("clear_gl", 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int y = 0; y < VD; y++) send_line(HD, -1, y == VD - 1);
        frame_edge_scenario("open_line", 1'b0);
        send_frame(VD, -1, -1);
        frame_edge_scenario("after_open", 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(2, 5);
            for (int y = 0; y < n; y++) begin
                int len;
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 11) : HD;
                send_line(len, -1, (y == n - 1) && ($urandom_range(0, 3) == 0));
            end
            frame_edge_scenario("random", $urandom_range(0, 3) == 0);
        end
    endtask

    task automatic test_reset_mid();
        send_frame(VD, -1, -1);
        frame_edge_scenario("pre_rst", 1'b0);
        vin_valid = 1'b1;
        vin_data  = DW'($urandom);
        step();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({meas_xres, meas_yres, meas_valid, frame_done, frame_cnt, frame_sum, err_line, err_frame, err_sync} !== '0) begin
            errors++; $display("FAIL async_reset: got cnt=%0d sum=%0d valid=%0d expected all 0",
                               frame_cnt, frame_sum, meas_valid);
        end
        $display("async reset mid-line cnt=%0d", frame_cnt);
        vin_valid = 1'b0;
        model_clear_outputs();
        step();
        step();
        rst_n = 1'b1;
        step();
        send_line(HD, -1, 1'b0);
        frame_edge_scenario("relock", 1'b0);
        send_frame(VD, -1, -1);
        frame_edge_scenario("post_rst", 1'b0);
    endtask

    initial begin
        test_reset();
        test_prelock();
        test_clean();
        test_short_line();
        test_tall_and_empty();
        test_sync_glitch();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
